// File: rtl/lcd_scene_scheduler_pkg.sv
// Shared types and constants for the LCD scene scheduler: FSM encoding,
// patient/counter index type and parameter defaults.
package lcd_scene_scheduler_pkg;

    localparam int DEF_NUM_PATIENTS = 8;
    localparam int DEF_DWELL_FRAMES = 4;

    typedef logic [3:0] idx_t;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_FETCH_ROM = 3'd1;
    localparam logic [2:0] ST_FETCH_RAM = 3'd2;
    localparam logic [2:0] ST_LATCH     = 3'd3;
    localparam logic [2:0] ST_SHOW      = 3'd4;

    // Wrapping increment; anything at or past the last index returns to 0.
    function automatic idx_t next_index(input idx_t cur, input idx_t last);
        return (cur >= last) ? '0 : cur + 4'd1;
    endfunction

endpackage

// File: rtl/lcd_scene_scheduler_scene_dwell_counter.sv
// Per-frame dwell counter: decides scene toggles and patient advances on
// each completed frame seen while the scheduler is showing a snapshot.
module scene_dwell_counter
    import lcd_scene_scheduler_pkg::*;
#(
    parameter int NUM_PATIENTS = DEF_NUM_PATIENTS,
    parameter int DWELL_FRAMES = DEF_DWELL_FRAMES
) (
    input  logic clk,
    input  logic reset,
    input  logic step,
    input  logic advance,
    input  logic hold,
    output logic scene,
    output idx_t patient,
    output idx_t count
);

    localparam idx_t LAST_PATIENT = idx_t'(NUM_PATIENTS - 1);
    localparam idx_t LAST_COUNT   = idx_t'(DWELL_FRAMES - 1);

    logic scene_q, scene_d;
    idx_t patient_q, patient_d;
    idx_t count_q, count_d;
    idx_t patient_next;

    always_comb begin
        scene_d      = scene_q;
        patient_d    = patient_q;
        count_d      = count_q;
        patient_next = next_index(patient_q, LAST_PATIENT);
        if (step) begin
            // A user advance overrides the dwell rule for this frame.
            if (advance) begin
                patient_d = patient_next;
                scene_d   = 1'b1;
                count_d   = '0;
            end else if (count_q >= LAST_COUNT) begin
                if (!hold) begin
                    count_d = '0;
                    scene_d = ~scene_q;
                    if (!scene_q) begin
                        patient_d = patient_next;
                    end
                end
            end else begin
                count_d = count_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scene_q   <= 1'b1;
            patient_q <= '0;
            count_q   <= '0;
        end else begin
            scene_q   <= scene_d;
            patient_q <= patient_d;
            count_q   <= count_d;
        end
    end

    assign scene   = scene_q;
    assign patient = patient_q;
    assign count   = count_q;

endmodule

// File: rtl/lcd_scene_scheduler.sv
// Fetches a patient's ROM/RAM words and live pill timers into frame-stable
// shadow registers, then holds them for the LCD until each frame completes.
module lcd_scene_scheduler
    import lcd_scene_scheduler_pkg::*;
#(
    parameter int NUM_PATIENTS = DEF_NUM_PATIENTS,
    parameter int DWELL_FRAMES = DEF_DWELL_FRAMES
) (
    input  logic        clkOneMilliSecond,
    input  logic        reset,
    input  logic        frameDone,
    input  logic        patientNext,
    input  logic        holdScene,
    input  logic [27:0] romData,
    input  logic [27:0] ramData,
    input  logic [11:0] pillDurations,
    output logic [3:0]  romAddress,
    output logic [3:0]  ramAddress,
    output logic        ramReadEn,
    output logic [27:0] romContent,
    output logic [27:0] dataFromRAM,
    output logic [11:0] pill12And3Duration,
    output logic        monitorOrMissedScene,
    output logic        frameValid,
    output logic [2:0]  debug_state,
    output logic [3:0]  debug_dwell_count
);

    logic [2:0]  state_q, state_d;
    logic        frame_valid_q, frame_valid_d;
    logic [27:0] rom_content_q, rom_content_d;
    logic [27:0] ram_data_q, ram_data_d;
    logic [11:0] pill_q, pill_d;
    logic        pending_q, pending_d;
    logic        show_done;
    logic        scene;
    idx_t        patient;
    idx_t        dwell_count;

    // frameDone only counts while a snapshot is on display.
    assign show_done = (state_q == ST_SHOW) && frameDone;

    always_comb begin
        state_d       = state_q;
        frame_valid_d = frame_valid_q;
        rom_content_d = rom_content_q;
        ram_data_d    = ram_data_q;
        pill_d        = pill_q;
        case (state_q)
            ST_IDLE:      state_d = ST_FETCH_ROM;
            ST_FETCH_ROM: state_d = ST_FETCH_RAM;
            ST_FETCH_RAM: begin
                rom_content_d = romData;
                state_d       = ST_LATCH;
            end
            ST_LATCH: begin
                ram_data_d    = ramData;
                pill_d        = pillDurations;
                frame_valid_d = 1'b1;
                state_d       = ST_SHOW;
            end
            ST_SHOW: begin
                if (frameDone) begin
                    frame_valid_d = 1'b0;
                    state_d       = ST_FETCH_ROM;
                end
            end
            default: begin
                frame_valid_d = 1'b0;
                state_d       = ST_IDLE;
            end
        endcase
    end

    // Several patientNext pulses between frames collapse into one advance.
    assign pending_d = show_done ? 1'b0 : (pending_q | patientNext);

    always_ff @(posedge clkOneMilliSecond) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            frame_valid_q <= 1'b0;
            rom_content_q <= '0;
            ram_data_q    <= '0;
            pill_q        <= '0;
            pending_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            frame_valid_q <= frame_valid_d;
            rom_content_q <= rom_content_d;
            ram_data_q    <= ram_data_d;
            pill_q        <= pill_d;
            pending_q     <= pending_d;
        end
    end

    scene_dwell_counter #(
        .NUM_PATIENTS (NUM_PATIENTS),
        .DWELL_FRAMES (DWELL_FRAMES)
    ) u_dwell (
        .clk     (clkOneMilliSecond),
        .reset   (reset),
        .step    (show_done),
        .advance (pending_q | patientNext),
        .hold    (holdScene),
        .scene   (scene),
        .patient (patient),
        .count   (dwell_count)
    );

    assign romAddress           = patient;
    assign ramAddress           = patient;
    assign ramReadEn            = (state_q == ST_FETCH_RAM);
    assign romContent           = rom_content_q;
    assign dataFromRAM          = ram_data_q;
    assign pill12And3Duration   = pill_q;
    assign monitorOrMissedScene = scene;
    assign frameValid           = frame_valid_q;
    assign debug_state          = state_q;
    assign debug_dwell_count    = dwell_count;

endmodule
